// File: rtl/m_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Holds the pipeline while a divide runs; done pulses once per result.
module m_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      m_con,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(XLEN-1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            isrem_q, isrem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;

  logic is_idle;
  logic is_calc;
  logic is_done;
  logic req;
  logic accept;

  assign is_idle = (state_q == IDLE);
  assign is_calc = (state_q == CALC);
  assign is_done = (state_q == DONE);
  assign req     = start & m_con[3];
  assign accept  = is_idle & req & ~flush;

  logic            sgn_op;
  logic            rem_op;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] spc_res;

  assign sgn_op   = ~m_con[0];
  assign rem_op   = m_con[1];
  assign a_neg    = sgn_op & op_a[XLEN-1];
  assign b_neg    = sgn_op & op_b[XLEN-1];
  assign a_abs    = a_neg ? -op_a : op_a;
  assign b_abs    = b_neg ? -op_b : op_b;
  assign div_zero = (op_b == '0);
  assign ovf      = sgn_op
                  & (op_a == MINV)
                  & (op_b == '1);

  // Results that bypass the iterative loop.
  always_comb begin
    spc_res = '0;
    unique case (1'b1)
      div_zero & ~rem_op: spc_res = '1;
      div_zero &  rem_op: spc_res = op_a;
      ovf & ~rem_op:      spc_res = MINV;
      default:            spc_res = '0;
    endcase
  end

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic            fits;

  // Dividend bits shift out of quo_q into the partial remainder.
  assign rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign fits   = ~diff[XLEN];
  assign rem_nx = fits ? diff : rem_sh;
  assign quo_nx = {quo_q[XLEN-2:0], fits};
  assign q_fin  = qneg_q ? -quo_nx : quo_nx;
  assign r_fin  = rneg_q ? -rem_nx[XLEN-1:0]
                         : rem_nx[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    isrem_d = isrem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          isrem_d = rem_op;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          if (div_zero | ovf) begin
            state_d = DONE;
            res_d   = spc_res;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            res_d   = isrem_q ? r_fin : q_fin;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      isrem_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      isrem_q <= isrem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{m_con[2], rem_q[XLEN]};

  assign stall  = rst_n & ((is_idle & req) | is_calc);
  assign done   = is_done & ~flush;
  assign result = res_q;

endmodule
